// File: rtl/conv_pp_pkg.sv
// Shared types and saturating-arithmetic helpers for the streaming convolver.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package conv_pp_pkg;

   typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} conv_state_t;

   // Number of valid-mode outputs produced per x vector.
   function automatic int nout_f(input int lenx, input int lenf);
      return lenx - lenf + 1;
   endfunction

   // Largest value representable in a signed field of the given width.
   function automatic logic signed [63:0] ymax_f(input int width);
      return (64'sd1 <<< (width - 1)) - 64'sd1;
   endfunction

   // Smallest value representable in a signed field of the given width.
   function automatic logic signed [63:0] ymin_f(input int width);
      return -(64'sd1 <<< (width - 1));
   endfunction

   // Clamp a wide signed value into the signed range of the given width.
   function automatic logic signed [63:0] sat_w(input logic signed [63:0] value,
                                                input int                 width);
      if (value > ymax_f(width))
         return ymax_f(width);
      else if (value < ymin_f(width))
         return ymin_f(width);
      else
         return value;
   endfunction

endpackage

// File: rtl/conv_mem.sv
// Simple dual-port memory: one synchronous write port, one registered read port.
// Latency: read data appears one clock after the read address.
// Backpressure: none; the owner sequences reads and writes.
// Ports: clk; we/waddr/wdata write port; raddr in, rdata out (registered).
module conv_mem #(
   parameter int WIDTH = 11,
   parameter int AW    = 5
)(
   input  logic             clk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [0:(1<<AW)-1];

   // Storage is deliberately not reset; readers only consume locations they
   // have previously written.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/conv_sat_mac.sv
// Registered multiply / saturate / accumulate stage for one convolution tap.
// Latency: acc reflects an enabled tap one clock after en.
// Backpressure: none; clr has priority over en, acc holds when neither is set.
// Ports: clk, reset (async active-low); clr, en controls; x, f signed operands; acc result.
module conv_sat_mac
   import conv_pp_pkg::*;
#(
   parameter int WIDTH = 11
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clr,
   input  logic                    en,
   input  logic signed [WIDTH-1:0] x,
   input  logic signed [WIDTH-1:0] f,
   output logic signed [WIDTH-1:0] acc
);

   logic signed [2*WIDTH-1:0] prod;
   logic signed [WIDTH-1:0]   p_sat;
   logic signed [WIDTH:0]     sum;
   logic signed [WIDTH-1:0]   acc_nxt;

   // Product is clamped to WIDTH before accumulation; the sum is formed one bit
   // wider so overflow is visible to the second clamp.
   always_comb begin
      prod    = x * f;
      p_sat   = WIDTH'(sat_w(64'(prod), WIDTH));
      sum     = (WIDTH+1)'(acc) + (WIDTH+1)'(p_sat);
      acc_nxt = WIDTH'(sat_w(64'(sum), WIDTH));
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         acc <= '0;
      else if (clr)
         acc <= '0;
      else if (en)
         acc <= acc_nxt;
   end

endmodule

// File: rtl/conv_stream_pp.sv
// Streaming 1-D valid-mode convolver, run-time filter, ping-pong x banks, saturating MAC.
// Latency: LENF+2 clocks from start of MAC to m_valid_y; LENF+3 clock output spacing.
// Backpressure: y held stable until m_ready_y, compute stalls; s_ready_x low while target bank full.
// Ports: clk, reset (async active-low); x stream (s_data_in_x/s_valid_x/s_ready_x);
//        filter stream (s_data_in_f/s_valid_f/s_ready_f, tap 0 first); y stream (m_data_out_y/m_valid_y/m_ready_y).
module conv_stream_pp
   import conv_pp_pkg::*;
#(
   parameter int WIDTH = 11,
   parameter int LENX  = 30,
   parameter int LENF  = 9,
   parameter int RELU  = 1,
   parameter int ADDRX = $clog2(LENX),
   parameter int ADDRF = $clog2(LENF)
)(
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] s_data_in_x,
   input  logic                    s_valid_x,
   output logic                    s_ready_x,
   input  logic signed [WIDTH-1:0] s_data_in_f,
   input  logic                    s_valid_f,
   output logic                    s_ready_f,
   output logic signed [WIDTH-1:0] m_data_out_y,
   output logic                    m_valid_y,
   input  logic                    m_ready_y
);

   // Keep counters at least one bit wide so single-entry configurations still elaborate.
   localparam int AX   = (ADDRX < 1) ? 1 : ADDRX;
   localparam int AF   = (ADDRF < 1) ? 1 : ADDRF;
   localparam int NOUT = nout_f(LENX, LENF);
   localparam logic [AX-1:0] X_LAST = AX'(LENX - 1);
   localparam logic [AX-1:0] I_LAST = AX'(NOUT - 1);
   localparam logic [AF-1:0] F_LAST = AF'(LENF - 1);

   conv_state_t             state;
   logic                    alive;
   logic                    w, r;
   logic [1:0]              full, full_nxt;
   logic [AX-1:0]           x_cnt, i_idx;
   logic [AF-1:0]           f_cnt, k_idx;
   logic                    f_valid;
   logic                    rd_vld, drain;
   logic                    x_acc, f_acc, x_last, done, idle;
   logic [AX:0]             x_waddr, x_raddr;
   logic [WIDTH-1:0]        x_rdata, f_rdata;
   logic signed [WIDTH-1:0] acc, y_nxt;

   assign x_acc   = s_valid_x && s_ready_x;
   assign f_acc   = s_valid_f && s_ready_f;
   assign x_last  = (x_cnt == X_LAST);
   assign done    = (state == OUT) && m_ready_y && (i_idx == I_LAST);
   assign idle    = (state == IDLE) && (full == 2'b00);

   // alive keeps both readies low through reset and releases them one clock later.
   assign s_ready_x = alive && !full[w];
   assign s_ready_f = alive && (!f_valid || idle);

   // Bank index is the address MSB: writer uses w, reader uses r.
   assign x_waddr = {w, x_cnt};
   assign x_raddr = {r, i_idx + AX'(k_idx)};

   assign y_nxt = ((RELU != 0) && (acc < 0)) ? '0 : acc;

   // Writer fill and reader release can land on different banks in one cycle.
   always_comb begin
      full_nxt = full;
      if (done)
         full_nxt[r] = 1'b0;
      if (x_acc && x_last)
         full_nxt[w] = 1'b1;
   end

   conv_mem #(.WIDTH(WIDTH), .AW(AX+1)) u_xmem (
      .clk   (clk),
      .we    (x_acc),
      .waddr (x_waddr),
      .wdata (s_data_in_x),
      .raddr (x_raddr),
      .rdata (x_rdata)
   );

   conv_mem #(.WIDTH(WIDTH), .AW(AF)) u_fmem (
      .clk   (clk),
      .we    (f_acc),
      .waddr (f_cnt),
      .wdata (s_data_in_f),
      .raddr (k_idx),
      .rdata (f_rdata)
   );

   conv_sat_mac #(.WIDTH(WIDTH)) u_mac (
      .clk   (clk),
      .reset (reset),
      .clr   ((state == MAC) && (k_idx == '0)),
      .en    (rd_vld),
      .x     ($signed(x_rdata)),
      .f     ($signed(f_rdata)),
      .acc   (acc)
   );

   // X bank writer.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alive <= 1'b0;
         w     <= 1'b0;
         x_cnt <= '0;
         full  <= 2'b00;
      end else begin
         alive <= 1'b1;
         full  <= full_nxt;
         if (x_acc) begin
            if (x_last) begin
               x_cnt <= '0;
               w     <= ~w;
            end else begin
               x_cnt <= x_cnt + AX'(1);
            end
         end
      end
   end

   // Filter loader: any accepted tap invalidates until the last tap lands.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         f_cnt   <= '0;
         f_valid <= 1'b0;
      end else if (f_acc) begin
         if (f_cnt == F_LAST) begin
            f_cnt   <= '0;
            f_valid <= 1'b1;
         end else begin
            f_cnt   <= f_cnt + AF'(1);
            f_valid <= 1'b0;
         end
      end
   end

   // Compute FSM. DRAIN spends two cycles: one for the memory read, one for the MAC register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         r            <= 1'b0;
         i_idx        <= '0;
         k_idx        <= '0;
         drain        <= 1'b0;
         rd_vld       <= 1'b0;
         m_valid_y    <= 1'b0;
         m_data_out_y <= '0;
      end else begin
         rd_vld <= (state == MAC);
         case (state)
            IDLE: begin
               if (full[r] && f_valid) begin
                  k_idx <= '0;
                  state <= MAC;
               end
            end
            MAC: begin
               if (k_idx == F_LAST) begin
                  drain <= 1'b0;
                  state <= DRAIN;
               end else begin
                  k_idx <= k_idx + AF'(1);
               end
            end
            DRAIN: begin
               if (drain) begin
                  m_valid_y    <= 1'b1;
                  m_data_out_y <= y_nxt;
                  state        <= OUT;
               end else begin
                  drain <= 1'b1;
               end
            end
            OUT: begin
               if (m_ready_y) begin
                  m_valid_y <= 1'b0;
                  k_idx     <= '0;
                  if (i_idx == I_LAST) begin
                     i_idx <= '0;
                     r     <= ~r;
                     state <= IDLE;
                  end else begin
                     i_idx <= i_idx + AX'(1);
                     state <= MAC;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_conv_stream_pp.sv
// Bench for conv_stream_pp: two instances (RELU=0 and RELU=1) share all inputs.
// Latency: n/a.
// Backpressure: consumer ready is driven randomly in some phases.
module tb_conv_stream_pp;

   localparam int W      = 8;
   localparam int LX     = 8;
   localparam int LF     = 4;
   localparam int NO     = LX - LF + 1;
   localparam int BUDGET = 3000;

   logic clk = 1'b0;
   logic reset = 1'b0;
   logic signed [W-1:0] s_data_in_x, s_data_in_f;
   logic s_valid_x, s_valid_f, m_ready_y;
   logic s_ready_x0, s_ready_f0, m_valid_y0;
   logic s_ready_x1, s_ready_f1, m_valid_y1;
   logic signed [W-1:0] y0, y1;

   int tests = 0;
   int fails = 0;
   int exp0[$];
   int exp1[$];
   int fil[LF];

   always #5 clk = ~clk;

   conv_stream_pp #(.WIDTH(W), .LENX(LX), .LENF(LF), .RELU(0)) u_dut0 (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x0),
      .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f0),
      .m_data_out_y(y0), .m_valid_y(m_valid_y0), .m_ready_y(m_ready_y)
   );

   conv_stream_pp #(.WIDTH(W), .LENX(LX), .LENF(LF), .RELU(1)) u_dut1 (
      .clk(clk), .reset(reset),
      .s_data_in_x(s_data_in_x), .s_valid_x(s_valid_x), .s_ready_x(s_ready_x1),
      .s_data_in_f(s_data_in_f), .s_valid_f(s_valid_f), .s_ready_f(s_ready_f1),
      .m_data_out_y(y1), .m_valid_y(m_valid_y1), .m_ready_y(m_ready_y)
   );

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
      end
   endtask

   function automatic int sat(input int v);
      int hi, lo;
      hi = (1 << (W - 1)) - 1;
      lo = -(1 << (W - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // Reference: valid-mode convolution over each whole LX chunk of xs with the current filter.
   function automatic void expect_x(input int xs[$]);
      for (int v = 0; v + LX <= xs.size(); v += LX) begin
         for (int i = 0; i < NO; i++) begin
            int acc;
            acc = 0;
            for (int k = 0; k < LF; k++)
               acc = sat(acc + sat(xs[v+i+k] * fil[k]));
            exp0.push_back(acc);
            exp1.push_back((acc < 0) ? 0 : acc);
         end
      end
   endfunction

   task automatic load_f(input int t[$]);
      int n;
      for (int j = 0; j < LF; j++) begin
         fil[j]      = t[j];
         s_data_in_f = W'(t[j]);
         s_valid_f   = 1'b1;
         n = 0;
         while (!s_ready_f0 && n < BUDGET) begin
            @(negedge clk);
            n++;
         end
         if (n >= BUDGET) check("f_ready_timeout", n, 0);
         @(negedge clk);
      end
      s_valid_f = 1'b0;
   endtask

   task automatic send_x(input int xs[$], output int st_early, output int st_total);
      int n;
      st_early = 0;
      st_total = 0;
      for (int j = 0; j < xs.size(); j++) begin
         s_data_in_x = W'(xs[j]);
         s_valid_x   = 1'b1;
         n = 0;
         while (!s_ready_x0 && n < BUDGET) begin
            @(negedge clk);
            n++;
         end
         if (n >= BUDGET) check("x_ready_timeout", n, 0);
         st_total += n;
         if (j < 2 * LX) st_early += n;
         @(negedge clk);
      end
      s_valid_x = 1'b0;
   endtask

   task automatic collect(input int n, input int pct, input bit chk_spacing);
      int got, cyc, last, e0, e1;
      logic held;
      logic signed [W-1:0] hd;
      got = 0; cyc = 0; last = -1; held = 1'b0; hd = '0;
      while (got < n && cyc < BUDGET) begin
         m_ready_y = (pct >= 100) ? 1'b1 : (int'($urandom_range(0, 99)) < pct);
         if (m_valid_y0) begin
            if (held) check("y_stable", y0, hd);
            if (m_ready_y) begin
               e0 = (exp0.size() > 0) ? exp0.pop_front() : 9999;
               e1 = (exp1.size() > 0) ? exp1.pop_front() : 9999;
               check("y_relu0", y0, e0);
               check("y_relu1", y1, e1);
               check("valid_relu1", m_valid_y1, 1);
               if (chk_spacing && last >= 0 && (got % NO) != 0)
                  check("spacing", cyc - last, LF + 3);
               last = cyc;
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hd   = y0;
            end
         end
         @(negedge clk);
         cyc++;
      end
      m_ready_y = 1'b0;
      if (got < n) check("collect_timeout", got, n);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int q[$];
      int fq[$];
      int st_e, st_t, lat, sv;

      s_data_in_x = '0; s_valid_x = 1'b0;
      s_data_in_f = '0; s_valid_f = 1'b0;
      m_ready_y   = 1'b0;
      repeat (3) @(negedge clk);

      // Reset state.
      check("rst_valid", m_valid_y0, 0);
      check("rst_y", y0, 0);
      check("rst_ready_x", s_ready_x0, 0);
      check("rst_ready_f", s_ready_f0, 0);
      check("rst_ready_x1", s_ready_x1, 0);
      check("rst_ready_f1", s_ready_f1, 0);
      reset = 1'b1;
      @(negedge clk);
      check("ready_x_up", s_ready_x0, 1);
      check("ready_f_up", s_ready_f0, 1);

      // Unit filter over a ramp, with first-output latency and idle afterwards.
      fq = {1, 1, 1, 1};
      load_f(fq);
      q = {};
      for (int j = 1; j <= LX; j++) q.push_back(j);
      expect_x(q);
      send_x(q, st_e, st_t);
      lat = 0;
      while (!m_valid_y0 && lat < BUDGET) begin
         @(negedge clk);
         lat++;
      end
      check("latency", lat, LF + 3);
      collect(NO, 100, 1'b1);
      repeat (20) @(negedge clk);
      check("idle_valid", m_valid_y0, 0);
      check("idle_ready_f", s_ready_f0, 1);
      check("idle_ready_x", s_ready_x0, 1);

      // Saturation, positive and negative.
      fq = {127, 127, 127, 127};
      load_f(fq);
      q = {};
      for (int j = 0; j < LX; j++) q.push_back(127);
      expect_x(q);
      send_x(q, st_e, st_t);
      collect(NO, 100, 1'b1);
      fq = {-128, -128, -128, -128};
      load_f(fq);
      expect_x(q);
      send_x(q, st_e, st_t);
      collect(NO, 100, 1'b1);

      // Negative filter: RELU=0 passes negatives, RELU=1 clamps.
      fq = {-1, -1, -1, -1};
      load_f(fq);
      q = {};
      for (int j = 1; j <= LX; j++) q.push_back(j);
      expect_x(q);
      send_x(q, st_e, st_t);
      collect(NO, 100, 1'b1);

      // Ping-pong: two vectors back to back with valid held high.
      fq = {1, 1, 1, 1};
      load_f(fq);
      q = {};
      for (int j = 1; j <= LX; j++) q.push_back(j);
      for (int j = LX; j >= 1; j--) q.push_back(j);
      expect_x(q);
      send_x(q, st_e, st_t);
      check("pingpong_no_stall", st_t, 0);
      collect(2 * NO, 100, 1'b1);

      // Backpressure: three vectors, random ready; the third must stall.
      q = {};
      for (int j = 1; j <= LX; j++) q.push_back(j);
      for (int j = LX; j >= 1; j--) q.push_back(j);
      for (int j = 0; j < LX; j++) q.push_back(int'($urandom_range(0, 255)) - 128);
      expect_x(q);
      fork
         send_x(q, st_e, st_t);
         collect(3 * NO, 30, 1'b0);
      join
      check("bp_first_two_no_stall", st_e, 0);
      check("bp_third_stalls", (st_t > 0) ? 1 : 0, 1);

      // Random filters and vectors; taps offered while busy must be ignored.
      for (int it = 0; it < 4; it++) begin
         fq = {};
         for (int k = 0; k < LF; k++) fq.push_back(int'($urandom_range(0, 255)) - 128);
         load_f(fq);
         q = {};
         for (int j = 0; j < LX; j++) q.push_back(int'($urandom_range(0, 255)) - 128);
         expect_x(q);
         send_x(q, st_e, st_t);
         s_data_in_f = W'(55);
         s_valid_f   = 1'b1;
         repeat (3) begin
            check("ready_f_busy", s_ready_f0, 0);
            @(negedge clk);
         end
         s_valid_f = 1'b0;
         collect(NO, 60, 1'b0);
      end

      // Reset while a result is pending: valid must drop asynchronously.
      fq = {2, 1, 1, 1};
      load_f(fq);
      q = {};
      for (int j = 1; j <= LX; j++) q.push_back(j);
      send_x(q, st_e, st_t);
      lat = 0;
      while (!m_valid_y0 && lat < BUDGET) begin
         @(negedge clk);
         lat++;
      end
      check("pending_valid", m_valid_y0, 1);
      #2 reset = 1'b0;
      #1;
      check("async_valid", m_valid_y0, 0);
      check("async_y", y0, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Reset during the third MAC cycle of a vector.
      fq = {1, 1, 1, 1};
      load_f(fq);
      send_x(q, st_e, st_t);
      repeat (3) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      check("mac_rst_valid", m_valid_y0, 0);
      check("mac_rst_y", y0, 0);
      check("mac_rst_ready_x", s_ready_x0, 0);
      check("mac_rst_ready_f", s_ready_f0, 0);
      @(negedge clk);
      reset = 1'b1;
      sv = 0;
      repeat (10) begin
         @(negedge clk);
         sv += int'(m_valid_y0);
      end
      check("no_stale_y", sv, 0);
      exp0.delete();
      exp1.delete();
      fq = {1, 1, 1, 1};
      load_f(fq);
      q = {};
      for (int j = LX; j >= 1; j--) q.push_back(j);
      expect_x(q);
      send_x(q, st_e, st_t);
      collect(NO, 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
